// File: rtl/ks_adder_pipe.sv
// rtl/ks_adder_pipe.sv - pipelined Kogge-Stone adder with valid/ready handshake and global stall
// Optional subtract mode when KS_ADDER_SUB_EN is defined (adds the sub input port).
module ks_adder_pipe #(
  parameter int WIDTH       = 8,
  parameter int PIPE_LEVELS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
`ifdef KS_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] c_o,
  output logic             cout
);

  localparam int L  = $clog2(WIDTH);
  localparam int NG = (L + PIPE_LEVELS - 1) / PIPE_LEVELS;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;

  // stage s holds the prefix state entering group s; the last stage holds the result
  logic [WIDTH-1:0] grp_g_r [NG];
  logic [WIDTH-1:0] grp_p_r [NG];
  logic [WIDTH-1:0] p_r     [NG];
  logic [NG-1:0]    c0_r;
  logic [NG:0]      vld;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] co_r;

  logic [WIDTH-1:0] nxt_g [NG];
  logic [WIDTH-1:0] nxt_p [NG];
  logic [WIDTH-1:0] gv, pv, gn, pn;
  logic [WIDTH-1:0] fin_g;
  logic [WIDTH-1:0] sum_nxt;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

`ifdef KS_ADDER_SUB_EN
  assign b_eff = b ^ {WIDTH{sub}};
  assign c_eff = c0 ^ sub;
`else
  assign b_eff = b;
  assign c_eff = c0;
`endif

  always_comb begin
    p_in    = a ^ b_eff;
    g_in    = a & b_eff;
    g_in[0] = g_in[0] | (p_in[0] & c_eff);
  end

  // level k belongs to group k/PIPE_LEVELS; the top level clips at the MSB for non-power-of-2 widths
  always_comb begin
    gv = '0;
    pv = '0;
    gn = '0;
    pn = '0;
    for (int s = 0; s < NG; s++) begin
      gv = grp_g_r[s];
      pv = grp_p_r[s];
      for (int k = 0; k < L; k++) begin
        if (k / PIPE_LEVELS == s) begin
          gn = gv;
          pn = pv;
          for (int i = (1 << k); i < WIDTH; i++) begin
            gn[i] = gv[i] | (pv[i] & gv[i - (1 << k)]);
            pn[i] = pv[i] & pv[i - (1 << k)];
          end
          gv = gn;
          pv = pn;
        end
      end
      nxt_g[s] = gv;
      nxt_p[s] = pv;
    end
  end

  assign fin_g   = nxt_g[NG-1];
  assign sum_nxt = p_r[NG-1] ^ {fin_g[WIDTH-2:0], c0_r[NG-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld   <= '0;
      c0_r  <= '0;
      sum_r <= '0;
      co_r  <= '0;
      for (int s = 0; s < NG; s++) begin
        grp_g_r[s] <= '0;
        grp_p_r[s] <= '0;
        p_r[s]     <= '0;
      end
    end else if (adv) begin
      vld        <= {vld[NG-1:0], in_valid};
      grp_g_r[0] <= g_in;
      grp_p_r[0] <= p_in;
      p_r[0]     <= p_in;
      c0_r[0]    <= c_eff;
      for (int s = 1; s < NG; s++) begin
        grp_g_r[s] <= nxt_g[s-1];
        grp_p_r[s] <= nxt_p[s-1];
        p_r[s]     <= p_r[s-1];
        c0_r[s]    <= c0_r[s-1];
      end
      sum_r <= sum_nxt;
      co_r  <= fin_g;
    end
  end

  assign out_valid = vld[NG];
  assign sum       = sum_r;
  assign c_o       = co_r;
  assign cout      = co_r[WIDTH-1];

endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb/tb_ks_adder_pipe.sv - directed bench for ks_adder_pipe (8-bit/1-level and 13-bit/2-level instances)
module tb_ks_adder_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic       c0 = 1'b0;
  logic       in_ready, out_valid, cout;
  logic [7:0] sum, c_o;
`ifdef KS_ADDER_SUB_EN
  logic       sub = 1'b0;
`endif

  logic        in_valid13 = 1'b0, out_ready13 = 1'b1;
  logic [12:0] a13 = '0, b13 = '0;
  logic        c013 = 1'b0, sub13 = 1'b0;
  logic        in_ready13, out_valid13, cout13;
  logic [12:0] sum13, c_o13;

  int n_cmp = 0;
  int n_err = 0;

  ks_adder_pipe #(.WIDTH(8), .PIPE_LEVELS(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c0(c0),
`ifdef KS_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .c_o(c_o), .cout(cout)
  );

  ks_adder_pipe #(.WIDTH(13), .PIPE_LEVELS(2)) u_dut13 (
    .clk(clk), .rst(rst), .in_valid(in_valid13), .in_ready(in_ready13),
    .a(a13), .b(b13), .c0(c013),
`ifdef KS_ADDER_SUB_EN
    .sub(sub13),
`endif
    .out_valid(out_valid13), .out_ready(out_ready13), .sum(sum13), .c_o(c_o13), .cout(cout13)
  );

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c);
    a = x; b = y; c0 = c; in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (sum !== 8'h00) begin n_err++; $display("FAIL reset_sum got=%h exp=00", sum); end
    n_cmp++; if (c_o !== 8'h00) begin n_err++; $display("FAIL reset_c_o got=%h exp=00", c_o); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got=%b exp=0", cout); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_latency();
    int lat;
    lat = 0;
    out_ready = 1'b1;
    send(8'hFF, 8'h00, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (out_valid) begin lat = n; break; end
      @(negedge clk);
    end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL latency got=%0d exp=4", lat); end
    n_cmp++; if (sum !== 8'h00) begin n_err++; $display("FAIL lat_sum got=%h exp=00", sum); end
    n_cmp++; if (c_o !== 8'hFF) begin n_err++; $display("FAIL lat_c_o got=%h exp=ff", c_o); end
    n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL lat_cout got=%b exp=1", cout); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_no_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3] = '{8'h55, 8'h01, 8'h20};
    logic [7:0] vb [3] = '{8'hAA, 8'h03, 8'h20};
    logic       vc [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] es [3] = '{8'h00, 8'h05, 8'h40};
    logic [7:0] ec [3] = '{8'hFF, 8'h03, 8'h20};
    logic       found;
    found = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(va[i], vb[i], vc[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL b2b_timeout got=%b exp=1", found); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, out_valid); end
      n_cmp++; if (sum !== es[i]) begin n_err++; $display("FAIL b2b_sum[%0d] got=%h exp=%h", i, sum, es[i]); end
      n_cmp++; if (c_o !== ec[i]) begin n_err++; $display("FAIL b2b_c_o[%0d] got=%h exp=%h", i, c_o, ec[i]); end
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_tail got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall();
    logic [7:0] va [4] = '{8'h10, 8'h0F, 8'h80, 8'h7F};
    logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h80, 8'h00};
    logic       vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] es [4] = '{8'h11, 8'h10, 8'h00, 8'h80};
    logic [7:0] ec [4] = '{8'h00, 8'h0F, 8'h80, 8'h7F};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(va[i], vb[i], vc[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", n, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got=%b exp=1", n, out_valid); end
      n_cmp++; if (sum !== es[0]) begin n_err++; $display("FAIL stall_sum[%0d] got=%h exp=%h", n, sum, es[0]); end
      n_cmp++; if (c_o !== ec[0]) begin n_err++; $display("FAIL stall_c_o[%0d] got=%h exp=%h", n, c_o, ec[0]); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, out_valid); end
      n_cmp++; if (sum !== es[i]) begin n_err++; $display("FAIL drain_sum[%0d] got=%h exp=%h", i, sum, es[i]); end
      n_cmp++; if (c_o !== ec[i]) begin n_err++; $display("FAIL drain_c_o[%0d] got=%h exp=%h", i, c_o, ec[i]); end
    end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL drain_cout got=%b exp=0", cout); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_no_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    logic stale;
    stale = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(8'(i + 1), 8'h02, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
    n_cmp++; if (sum !== 8'h00) begin n_err++; $display("FAIL mid_async_sum got=%h exp=00", sum); end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    n_cmp++; if (stale !== 1'b0) begin n_err++; $display("FAIL mid_stale got=%b exp=0", stale); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
  endtask

`ifdef KS_ADDER_SUB_EN
  task automatic test_sub();
    logic found;
    found = 1'b0;
    out_ready = 1'b1;
    sub = 1'b1;
    send(8'h10, 8'h01, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    sub = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (out_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL sub_timeout got=%b exp=1", found); end
    n_cmp++; if (sum !== 8'h0F) begin n_err++; $display("FAIL sub_sum got=%h exp=0f", sum); end
    n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL sub_cout got=%b exp=1", cout); end
    n_cmp++; if (c_o !== 8'hF0) begin n_err++; $display("FAIL sub_c_o got=%h exp=f0", c_o); end
    @(negedge clk);
  endtask
`endif

  task automatic test_random_w13();
    logic [12:0] q_sum [$];
    logic [12:0] q_c [$];
    logic        q_co [$];
    logic [12:0] be, cv;
    logic        ce, xfer;
    logic [13:0] full;
    int          sent, got;
    sent = 0; got = 0; xfer = 1'b1;
    in_valid13 = 1'b0;
    for (int cyc = 0; cyc < 2000 && got < 40; cyc++) begin
      @(negedge clk);
      out_ready13 = ($urandom_range(0, 3) != 0);
      if (xfer) begin
        if (sent < 40) begin
          a13 = 13'($urandom); b13 = 13'($urandom); c013 = 1'($urandom);
`ifdef KS_ADDER_SUB_EN
          sub13 = 1'($urandom);
`endif
          in_valid13 = 1'b1;
        end else begin
          in_valid13 = 1'b0;
        end
      end
      #1;
      if (out_valid13 && out_ready13) begin
        n_cmp++;
        if (q_sum.size() == 0) begin
          n_err++; $display("FAIL w13_unexpected got=%h exp=none", sum13);
        end else begin
          if (sum13 !== q_sum[0]) begin n_err++; $display("FAIL w13_sum[%0d] got=%h exp=%h", got, sum13, q_sum[0]); end
          n_cmp++; if (c_o13 !== q_c[0]) begin n_err++; $display("FAIL w13_c_o[%0d] got=%h exp=%h", got, c_o13, q_c[0]); end
          n_cmp++; if (cout13 !== q_co[0]) begin n_err++; $display("FAIL w13_cout[%0d] got=%b exp=%b", got, cout13, q_co[0]); end
          void'(q_sum.pop_front()); void'(q_c.pop_front()); void'(q_co.pop_front());
        end
        got++;
      end
      xfer = in_valid13 && in_ready13;
      if (xfer) begin
        be   = b13 ^ {13{sub13}};
        ce   = c013 ^ sub13;
        full = {1'b0, a13} + {1'b0, be} + 14'(ce);
        cv   = 13'(({1'b0, a13} ^ {1'b0, be} ^ full) >> 1);
        q_sum.push_back(full[12:0]); q_c.push_back(cv); q_co.push_back(full[13]);
        sent++;
      end
    end
    in_valid13 = 1'b0;
    n_cmp++; if (got !== 40) begin n_err++; $display("FAIL w13_count got=%0d exp=40", got); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
`ifdef KS_ADDER_SUB_EN
    test_sub();
`endif
    test_random_w13();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
